// File: rtl/eth_tx_dma.sv
// rtl/eth_tx_dma.sv - TX ring DMA: fetches length-prefixed frames from a RAM ring and streams them as beats
module eth_tx_dma #(
    parameter int DATA_WIDTH      = 32,
    parameter int RING_WORDS      = 256,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [15:0]                   ring_base,
    input  logic [$clog2(RING_WORDS)-1:0] wr_ptr,
    output logic [$clog2(RING_WORDS)-1:0] rd_ptr,
    output logic [15:0]                   ram_rd_addr,
    output logic                          ram_rd_valid,
    input  logic                          ram_rd_ready,
    input  logic [DATA_WIDTH-1:0]         ram_rd_data,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic [$clog2(DATA_WIDTH/8):0] tx_bytes,
    output logic                          busy,
    output logic                          err_len,
    output logic                          err_underrun,
    input  logic                          clr_err,
    output logic [15:0]                   frames_sent
);
    localparam int W  = DATA_WIDTH / 8;
    localparam int LW = $clog2(W);
    localparam int BW = LW + 1;
    localparam int PW = $clog2(RING_WORDS);

    typedef enum logic [2:0] {IDLE, HDR, PAY_RD, PAY_TX, COMMIT, DROP} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] offset;       // word offset from rd_ptr of the next read
    logic [15:0]   bytes_left;   // payload bytes not yet loaded into a beat
    logic [PW-1:0] occupancy;
    logic [PW-1:0] ring_idx;
    logic [15:0]   hdr_len;
    logic [16:0]   hdr_words;
    logic          hdr_bad_len;
    logic          hdr_underrun;
    logic          last_beat;
    logic          rd_hs;
    logic          tx_hs;
    logic          set_len;
    logic          set_under;

    assign occupancy    = wr_ptr - rd_ptr;
    assign ring_idx     = rd_ptr + offset;
    assign hdr_len      = ram_rd_data[15:0];
    assign hdr_words    = ({1'b0, hdr_len} + 17'(W - 1)) >> LW;
    assign hdr_bad_len  = (hdr_len == 16'd0) || (32'(hdr_len) > MAX_FRAME_BYTES);
    assign hdr_underrun = (hdr_words + 17'd1) > 17'(occupancy);
    assign last_beat    = (bytes_left <= 16'(W));
    assign rd_hs        = ram_rd_valid && ram_rd_ready;
    assign tx_hs        = tx_valid && tx_ready;
    assign set_len      = (state == HDR) && rd_hs && hdr_bad_len;
    assign set_under    = (state == HDR) && rd_hs && !hdr_bad_len && hdr_underrun;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision; a header is judged as soon as its read completes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && (occupancy != '0)) state_nxt = HDR;
            HDR:     if (rd_hs) state_nxt = (hdr_bad_len || hdr_underrun) ? DROP : PAY_RD;
            PAY_RD:  if (rd_hs) state_nxt = PAY_TX;
            PAY_TX:  if (tx_hs) state_nxt = tx_last ? COMMIT : PAY_RD;
            COMMIT:  state_nxt = IDLE;
            DROP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the address is parked at 0 when no read is requested
    always_comb begin
        busy         = (state != IDLE);
        ram_rd_valid = (state == HDR) || (state == PAY_RD);
        ram_rd_addr  = ram_rd_valid ? (ring_base + 16'(ring_idx)) : 16'd0;
    end

    // Datapath: read offset, byte countdown, beat register and ring commit
    always_ff @(posedge clk) begin
        if (rst) begin
            offset      <= '0;
            bytes_left  <= 16'd0;
            rd_ptr      <= '0;
            frames_sent <= 16'd0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            tx_bytes    <= '0;
        end else begin
            case (state)
                IDLE: offset <= '0;
                HDR: begin
                    if (rd_hs) begin
                        offset     <= PW'(1);
                        bytes_left <= hdr_len;
                    end
                end
                PAY_RD: begin
                    if (rd_hs) begin
                        tx_data  <= ram_rd_data;
                        tx_valid <= 1'b1;
                        tx_last  <= last_beat;
                        tx_bytes <= last_beat ? bytes_left[BW-1:0] : BW'(W);
                    end
                end
                PAY_TX: begin
                    if (tx_hs) begin
                        tx_valid   <= 1'b0;
                        offset     <= offset + PW'(1);
                        bytes_left <= bytes_left - 16'(W);
                    end
                end
                COMMIT: begin
                    // offset now equals 1 + N, the full footprint of the frame
                    rd_ptr      <= rd_ptr + offset;
                    frames_sent <= frames_sent + 16'd1;
                end
                DROP: rd_ptr <= wr_ptr;
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_len      <= set_len   || (err_len && !clr_err);
            err_underrun <= set_under || (err_underrun && !clr_err);
        end
    end
endmodule

// File: tb/tb_eth_tx_dma.sv
// tb/tb_eth_tx_dma.sv - self-checking bench for eth_tx_dma against a frame-level ring model
module tb_eth_tx_dma;
    localparam int W    = 4;
    localparam int RW   = 16;
    localparam int MAXB = 40;
    localparam int BASE = 256;

    logic        clk = 1'b0;
    logic        rst, enable, ram_rd_ready, tx_ready, clr_err;
    logic [15:0] ring_base;
    logic [3:0]  wr_ptr, rd_ptr;
    logic [15:0] ram_rd_addr;
    logic        ram_rd_valid;
    logic [31:0] ram_rd_data, tx_data;
    logic        tx_valid, tx_last;
    logic [2:0]  tx_bytes;
    logic        busy, err_len, err_underrun;
    logic [15:0] frames_sent;

    always #5 clk = ~clk;

    eth_tx_dma #(.DATA_WIDTH(32), .RING_WORDS(RW), .MAX_FRAME_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ring_base(ring_base),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .ram_rd_addr(ram_rd_addr),
        .ram_rd_valid(ram_rd_valid), .ram_rd_ready(ram_rd_ready), .ram_rd_data(ram_rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .tx_bytes(tx_bytes), .busy(busy), .err_len(err_len), .err_underrun(err_underrun),
        .clr_err(clr_err), .frames_sent(frames_sent)
    );

    logic [31:0] mem [0:511];
    assign ram_rd_data = mem[ram_rd_addr[8:0]];

    // Monitor: logs handshakes and counts protocol violations
    logic [15:0] got_addr [$];
    logic [31:0] got_data [$];
    logic [2:0]  got_bytes [$];
    logic        got_last [$];
    int          viol = 0;
    int          under_cnt = 0;
    logic        p_txstall = 1'b0, p_rdstall = 1'b0, p_last = 1'b0;
    logic [31:0] p_data = '0;
    logic [2:0]  p_bytes = '0;
    logic [15:0] p_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            p_txstall <= 1'b0;
            p_rdstall <= 1'b0;
        end else begin
            if (p_txstall && !(tx_valid && tx_data === p_data && tx_bytes === p_bytes && tx_last === p_last))
                viol++;
            if (p_rdstall && !(ram_rd_valid && ram_rd_addr === p_addr)) viol++;
            if (ram_rd_valid && tx_valid) viol++;
            if (ram_rd_valid && ram_rd_ready) got_addr.push_back(ram_rd_addr);
            if (tx_valid && tx_ready) begin
                got_data.push_back(tx_data);
                got_bytes.push_back(tx_bytes);
                got_last.push_back(tx_last);
            end
            if (err_underrun) under_cnt++;
            p_txstall <= tx_valid && !tx_ready;
            p_rdstall <= ram_rd_valid && !ram_rd_ready;
            p_data    <= tx_data;
            p_bytes   <= tx_bytes;
            p_last    <= tx_last;
            p_addr    <= ram_rd_addr;
        end
    end

    int vectors = 0;
    int errors  = 0;
    int exp_rd  = 0;
    int exp_frames = 0;
    bit rnd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            ram_rd_ready = 1'($urandom_range(0, 1));
            tx_ready     = 1'($urandom_range(0, 1));
            enable       = ($urandom_range(0, 3) != 0);
        end
    endtask

    function automatic int nwords(input int len);
        return (len + W - 1) / W;
    endfunction

    function automatic int slot(input int idx);
        return BASE + (idx % RW);
    endfunction

    task automatic put_frame(input int r0, input int len);
        mem[slot(r0)] = {16'($urandom), 16'(len)};
        for (int i = 0; i < nwords(len); i++) mem[slot(r0 + 1 + i)] = $urandom;
    endtask

    task automatic wait_done(input int budget, output int first_tv);
        bit saw = 0;
        bit done = 0;
        first_tv = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy) saw = 1;
            if (tx_valid && first_tv < 0) first_tv = i;
            if (saw && !busy) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("frame_done", done, 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tx"}, {tx_valid, tx_last, tx_bytes, tx_data}, 0);
        chk({tag, "_ram"}, {ram_rd_valid, ram_rd_addr}, 0);
        chk({tag, "_stat"}, {busy, err_len, err_underrun, frames_sent, rd_ptr}, 0);
    endtask

    // Compares the logged reads and beats of one legal frame with what the ring holds
    task automatic check_frame(input int r0, input int len, input int a0, input int b0);
        int nw = nwords(len);
        chk("n_reads", got_addr.size() - a0, nw + 1);
        for (int k = 0; k <= nw && a0 + k < got_addr.size(); k++)
            chk("rd_addr", got_addr[a0 + k], slot(r0 + k));
        chk("n_beats", got_data.size() - b0, nw);
        for (int i = 0; i < nw && b0 + i < got_data.size(); i++) begin
            int rem = len - W * i;
            int eb  = (rem < W) ? rem : W;
            chk("beat", {28'd0, got_last[b0 + i], got_bytes[b0 + i], got_data[b0 + i]},
                {28'd0, (i == nw - 1), 3'(eb), mem[slot(r0 + 1 + i)]});
        end
        exp_rd = (r0 + 1 + nw) % RW;
        exp_frames++;
        chk("rd_ptr", rd_ptr, exp_rd);
        chk("frames_sent", frames_sent, exp_frames);
        chk("no_viol", viol, 0);
    endtask

    task automatic do_frame(input int len, output int first_tv);
        int r0 = exp_rd;
        int a0 = got_addr.size();
        int b0 = got_data.size();
        put_frame(r0, len);
        wr_ptr = 4'((r0 + 1 + nwords(len)) % RW);
        wait_done(400, first_tv);
        check_frame(r0, len, a0, b0);
    endtask

    task automatic do_bad(input int len, input int occ, input logic e_len, input logic e_under);
        int r0 = exp_rd;
        int a0 = got_addr.size();
        int b0 = got_data.size();
        int ft;
        mem[slot(r0)] = {16'($urandom), 16'(len)};
        wr_ptr = 4'((r0 + occ) % RW);
        wait_done(100, ft);
        exp_rd = (r0 + occ) % RW;
        chk("err_flags", {err_len, err_underrun}, {e_len, e_under});
        chk("drop_rd_ptr", rd_ptr, exp_rd);
        chk("drop_reads", got_addr.size() - a0, 1);
        chk("drop_beats", got_data.size() - b0, 0);
        chk("drop_frames", frames_sent, exp_frames);
    endtask

    initial begin
        int ft;
        int r0, a0, b0, snap;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst = 1; enable = 1; ram_rd_ready = 1; tx_ready = 1; clr_err = 0;
        ring_base = 16'(BASE); wr_ptr = '0;
        tick(); tick(); tick();
        reset_checks("reset");
        rst = 0;
        tick();

        // 10-byte frame, ready held: beats 4,4,2 and a 3-cycle start latency
        do_frame(10, ft);
        chk("latency", ft, 3);

        // Advance to index 14 then run a frame that wraps the ring
        do_frame(36, ft);
        chk("pre_wrap_rd_ptr", rd_ptr, 14);
        do_frame(8, ft);
        chk("wrap_rd_ptr", rd_ptr, 1);

        // Boundary lengths: single byte and the largest legal frame
        do_frame(1, ft);
        do_frame(MAXB, ft);

        // Enable low holds a pending frame in IDLE
        enable = 0;
        r0 = exp_rd; a0 = got_addr.size(); b0 = got_data.size();
        put_frame(r0, 6);
        wr_ptr = 4'((r0 + 3) % RW);
        repeat (5) tick();
        chk("enable_hold", busy, 0);
        enable = 1;
        wait_done(100, ft);
        check_frame(r0, 6, a0, b0);

        // Back-pressure on beat 2 for five cycles
        r0 = exp_rd; a0 = got_addr.size(); b0 = got_data.size();
        put_frame(r0, 12);
        wr_ptr = 4'((r0 + 4) % RW);
        for (int i = 0; i < 50 && got_data.size() < b0 + 1; i++) tick();
        tx_ready = 0;
        repeat (6) tick();
        chk("stall_valid", tx_valid, 1);
        tx_ready = 1;
        wait_done(100, ft);
        check_frame(r0, 12, a0, b0);

        // Length errors, then clear
        do_bad(0, 3, 1'b1, 1'b0);
        do_bad(MAXB + 1, 2, 1'b1, 1'b0);
        do_bad(2000, 5, 1'b1, 1'b0);
        clr_err = 1; tick(); clr_err = 0;
        chk("clr_err_len", err_len, 0);

        // Underrun: 12 bytes need 4 words but only 2 are posted
        do_bad(12, 2, 1'b0, 1'b1);
        clr_err = 1; tick(); clr_err = 0;
        chk("clr_err_under", err_underrun, 0);

        // Error set wins over a clear held in the same cycle
        snap = under_cnt;
        clr_err = 1;
        do_bad(12, 2, 1'b0, 1'b0);
        clr_err = 0;
        chk("set_beats_clear", under_cnt > snap, 1);

        // Randomized frames with random ready and enable
        rnd = 1;
        for (int f = 0; f < 10; f++) do_frame($urandom_range(1, MAXB), ft);
        rnd = 0;
        ram_rd_ready = 1; tx_ready = 1; enable = 1;

        // Reset while beat 2 is being presented
        r0 = exp_rd; b0 = got_data.size();
        put_frame(r0, 12);
        wr_ptr = 4'((r0 + 4) % RW);
        for (int i = 0; i < 50 && got_data.size() < b0 + 1; i++) tick();
        tx_ready = 0;
        tick();
        chk("beat2_present", tx_valid, 1);
        rst = 1; wr_ptr = '0;
        tick();
        reset_checks("midrst");
        rst = 0; tx_ready = 1;
        tick();
        chk("post_rst_idle", {busy, tx_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
